// File: rtl/seq101_pkg.sv
// Shared encodings for the 101 sequence-detector family: the transmit
// FSM used by seq101_tx and the golden Moore tracker states.
package seq101_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    S0  = 2'd0,
    S1  = 2'd1,
    S10 = 2'd2
  } trk_state_e;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_LENW  = 4;
  localparam int unsigned DEF_CNTW  = 4;

endpackage : seq101_pkg

// File: rtl/seq101_if.sv
// Pattern-request / serial-stream bundle between a stimulus source and
// seq101_tx, plus the transmit FSM state for observation.
interface seq101_if
  import seq101_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LENW  = DEF_LENW,
  parameter int unsigned CNTW  = DEF_CNTW
) ();

  // Request side: start is a one-way request with no ready; it is only
  // honoured while busy=0, is dropped silently otherwise, and a request
  // with len=0 is dropped too. Stream side: x is meaningful only while
  // valid=1, one bit per clock, with no backpressure from the consumer.
  logic             start;
  logic [WIDTH-1:0] data;
  logic [LENW-1:0]  len;

  logic             x;
  logic             valid;
  logic             busy;
  logic             done;
  logic [CNTW-1:0]  exp_count;

  tx_state_e        tx_state;

  modport master (
    output start, data, len,
    input  x, valid, busy, done, exp_count, tx_state
  );

  modport slave (
    input  start, data, len,
    output x, valid, busy, done, exp_count, tx_state
  );

endinterface : seq101_if

// File: rtl/seq101_model.sv
// Golden Moore non-overlapping 101 tracker; advances only when en=1 and
// counts completed matches with saturation.
module seq101_model
  import seq101_pkg::*;
#(
  parameter int unsigned CNTW = DEF_CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic            bit_in,
  output logic [CNTW-1:0] count
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  trk_state_e      state_q;
  logic [CNTW-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S0;
      count_q <= '0;
    end else if (clr) begin
      state_q <= S0;
      count_q <= '0;
    end else if (en) begin
      case (state_q)
        S0:  state_q <= bit_in ? S1 : S0;
        S1:  state_q <= bit_in ? S1 : S10;
        S10: begin
          // A match restarts from S0 so its trailing 1 is not reused.
          state_q <= S0;
          if (bit_in && (count_q != CNT_MAX)) begin
            count_q <= count_q + 1'b1;
          end
        end
        default: state_q <= S0;
      endcase
    end
  end

  assign count = count_q;

endmodule : seq101_model

// File: rtl/seq101_tx.sv
// Serial stimulus transmitter: shifts a pattern out MSB-first, one bit per
// clock, while a golden tracker counts the non-overlapping 101 matches.
module seq101_tx
  import seq101_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LENW  = DEF_LENW,
  parameter int unsigned CNTW  = DEF_CNTW
) (
  input  logic     clk,
  input  logic     reset,
  seq101_if.slave  bus
);

  localparam logic [LENW-1:0] WIDTH_L = LENW'(WIDTH);

  tx_state_e        state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [LENW-1:0]  cnt_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [LENW-1:0]  len_clamped;
  logic             accept;

  assign len_clamped = (bus.len > WIDTH_L) ? WIDTH_L : bus.len;
  assign accept      = (state_q == IDLE) && bus.start && (bus.len != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SEND;
            shreg_q <= bus.data;
            cnt_q   <= len_clamped;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == LENW'(1)) begin
            state_q <= DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // The tracker consumes exactly the bits shown on x, one per valid edge.
  seq101_model #(
    .CNTW (CNTW)
  ) u_model (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .en     (valid_q),
    .bit_in (shreg_q[WIDTH-1]),
    .count  (bus.exp_count)
  );

  assign bus.x        = valid_q & shreg_q[WIDTH-1];
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tx_state = state_q;

endmodule : seq101_tx

// File: tb/tb_seq101_tx.sv
// Directed and randomized checks of seq101_tx against a queue-based model
// of the emitted stream and a greedy non-overlapping 101 count.
module tb_seq101_tx;
  import seq101_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  seq101_if #(.WIDTH(8), .LENW(4), .CNTW(4)) bus ();

  seq101_tx #(.WIDTH(8), .LENW(4), .CNTW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Greedy left-to-right count of non-overlapping 101 in the first upto bits.
  function automatic int count_101(input logic q[$], input int upto);
    int c;
    int i;
    c = 0;
    i = 0;
    while (i + 2 < upto) begin
      if (q[i] && !q[i+1] && q[i+2]) begin
        c++;
        i += 3;
      end else begin
        i++;
      end
    end
    return (c > 15) ? 15 : c;
  endfunction

  task automatic run_tx(input logic [7:0] d, input logic [3:0] l, input bit poke);
    int   n;
    int   exp_final;
    logic q[$];
    n = (l > 4'd8) ? 8 : int'(l);
    for (int i = 0; i < n; i++) q.push_back(d[7-i]);
    exp_final = count_101(q, n);
    bus.start = 1'b1;
    bus.data  = d;
    bus.len   = l;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check("x_bit", 32'(bus.x), 32'(q[i]));
      check("valid_send", 32'(bus.valid), 32'd1);
      check("busy_send", 32'(bus.busy), 32'd1);
      check("done_send", 32'(bus.done), 32'd0);
      check("cnt_running", 32'(bus.exp_count), 32'(count_101(q, i)));
      if (poke && i == 1) begin
        bus.start = 1'b1;
        bus.data  = ~d;
        bus.len   = 4'd8;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_done", 32'(bus.busy), 32'd1);
    check("valid_done", 32'(bus.valid), 32'd0);
    check("x_done", 32'(bus.x), 32'd0);
    check("cnt_final", 32'(bus.exp_count), 32'(exp_final));
    if (poke) begin
      bus.start = 1'b1;
      bus.len   = 4'd5;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("done_low", 32'(bus.done), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("valid_idle", 32'(bus.valid), 32'd0);
    check("cnt_hold", 32'(bus.exp_count), 32'(exp_final));
    if (poke) begin
      @(negedge clk);
      check("no_retx_busy", 32'(bus.busy), 32'd0);
      check("no_retx_valid", 32'(bus.valid), 32'd0);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.data  = '0;
    bus.len   = '0;
    #2;
    check("rst_x", 32'(bus.x), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_cnt", 32'(bus.exp_count), 32'd0);
    check("rst_state", 32'(bus.tx_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // full word, overlapping tracker would report 3
    run_tx(8'b10101101, 4'd8, 1'b0);
    check("tp_full_count", 32'(bus.exp_count), 32'd2);

    run_tx(8'b10100000, 4'd3, 1'b0);
    check("tp_len3_count", 32'(bus.exp_count), 32'd1);

    // len=0 request must leave everything untouched
    bus.start = 1'b1;
    bus.data  = 8'b10101010;
    bus.len   = 4'd0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("len0_busy", 32'(bus.busy), 32'd0);
      check("len0_valid", 32'(bus.valid), 32'd0);
      check("len0_done", 32'(bus.done), 32'd0);
      check("len0_cnt", 32'(bus.exp_count), 32'd1);
      @(negedge clk);
    end

    run_tx(8'hFF, 4'd12, 1'b0);
    check("tp_clamp_count", 32'(bus.exp_count), 32'd0);

    // start pulses during SEND and DONE are ignored
    run_tx(8'b01011010, 4'd8, 1'b1);

    // reset in the middle of a transmission
    bus.start = 1'b1;
    bus.data  = 8'b10111111;
    bus.len   = 4'd8;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_x", 32'(bus.x), 32'd1);
    check("pre_rst_cnt", 32'(bus.exp_count), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_x", 32'(bus.x), 32'd0);
    check("mid_rst_valid", 32'(bus.valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_cnt", 32'(bus.exp_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_done", 32'(bus.done), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    run_tx(8'b11010010, 4'd8, 1'b0);

    // randomized transactions
    for (int t = 0; t < 30; t++) begin
      logic [7:0] rd;
      logic [3:0] rl;
      rd = 8'($urandom);
      rl = 4'($urandom_range(1, 15));
      run_tx(rd, rl, 1'($urandom_range(0, 1)) && (rl >= 4'd3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seq101_tx

// File: doc/seq101_tx.md
# seq101_tx

Serial stimulus transmitter for the 101 sequence-detector family. It accepts a parallel pattern word plus a bit count, and shifts the bits out MSB-first on the single-bit serial line `x` that the Moore non-overlapping detector consumes, one bit per clock. In parallel it runs a golden Moore non-overlapping 101 tracker over the emitted stream, so benches and self-test wrappers can compare the detector's `z` pulses against `exp_count`.

## Interface
- `WIDTH`, 8: pattern word width in bits; must be at least 3.
- `LENW`, 4: width of `len`; must satisfy 2^LENW > WIDTH.
- `CNTW`, 4: width of `exp_count`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces the whole block to its idle/reset values immediately.
- `start`  in  1  request to transmit; sampled only in IDLE.
- `data`  in  WIDTH  pattern; bit WIDTH-1 is sent first.
- `len`  in  LENW  number of bits to send; 0 means no transmission; values above WIDTH are clamped to WIDTH.
- `x`  out  1  serial bit to the detector.
- `valid`  out  1  high while `x` carries a pattern bit.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse after the last bit has been sent.
- `exp_count`  out  CNTW  number of non-overlapping 101 matches in the current or last stream.

## Operation
- Transmit FSM has three states:
  - IDLE: waits for a request. On `start`=1 with `len`≠0, load `shreg<=data`, load `cnt<=min(len,WIDTH)`, clear `exp_count` and the tracker, go to SEND. On `start` with `len`=0, stay in IDLE and change nothing.
  - SEND: drive `x`=`shreg[WIDTH-1]` and `valid`=1. Each edge shifts `shreg` left with 0 fill and decrements `cnt`. The edge where `cnt`=1 moves the FSM to DONE.
  - DONE: `done`=1 for exactly one cycle, then return to IDLE unconditionally.
- `start` is ignored in SEND and DONE. There is no queueing.
- Outputs are Moore, decoded from registered state only:
  - `x` = `valid` ? `shreg[WIDTH-1]` : 0.
  - `busy` = (state≠IDLE).
- Tracker is a Moore non-overlapping 101 recogniser with states S0, S1, S10. It advances only on edges where `valid`=1.
  - From S0: 1→S1, 0→S0.
  - From S1: 0→S10, 1→S1.
  - From S10: 1→S0 and increment `exp_count`; 0→S0.
  - Non-overlapping: after a match the tracker restarts from S0, so the trailing 1 is not reused.
- `exp_count` saturates at 2^CNTW−1.
- `exp_count` holds its final value from DONE until the next accepted `start`.

## Timing
- Reset values: state=IDLE, tracker=S0, `shreg`=0, `cnt`=0, `x`=0, `valid`=0, `busy`=0, `done`=0, `exp_count`=0.
- `start` is accepted at edge k:
  - Bit i (i=0..n−1, where n is the clamped length) is on `x` during cycle k+1+i.
  - `done` is high in cycle k+n+1.
  - IDLE resumes at edge k+n+2, so the earliest next accept is that edge.
- Bits change just after the rising edge. A downstream detector samples each bit on the following rising edge.
- `exp_count` updates at the edge that consumes the completing 1. It is final in the DONE cycle.
- Reset asserted mid-SEND: `x`, `valid` and `busy` drop to 0 and `exp_count` clears asynchronously. There is no `done` pulse.

## Structure
- Shared package `seq101_pkg`:
  - transmit state encodings: IDLE, SEND, DONE.
  - tracker state encodings: S0, S1, S10.
  - This package is also imported by the detector and the benches.
- Sub-module `seq101_model`: the tracker. Ports are `clk`, `reset`, `clr`, `en`, `bit_in` and `count`. It can be reused by other detector benches.

## Test plan
- WIDTH=8, `data`=8'b10101101, `len`=8, one `start` pulse:
  - `x` = 1,0,1,0,1,1,0,1 in cycles k+1..k+8.
  - `done` is high in cycle k+9.
  - `exp_count`=2. An overlapping tracker would give 3, so this case distinguishes the two.
- `data`=8'b10100000, `len`=3:
  - `x` = 1,0,1 then 0.
  - `done` in cycle k+4.
  - `exp_count`=1.
- `len`=0 with `start`=1:
  - `busy`, `valid` and `done` stay 0.
  - The previous `exp_count` is retained.
- `len`=12 (clamped), `data`=8'hFF: exactly 8 ones are sent, `exp_count`=0.
- `start` pulsed in SEND and again in DONE: both are ignored, and no retransmission starts.
- `reset` asserted in the middle of a transmission: all outputs return to their reset values immediately. After `reset` is released, a new `start` transmits correctly from bit WIDTH−1.
